// File: rtl/seq_recog_sched_pkg.sv
// seq_recog_pkg: shared encodings for the recognizer scheduler
package seq_recog_pkg;
  localparam logic [2:0] S_A = 3'd0;
  localparam logic [2:0] S_B = 3'd1;
  localparam logic [2:0] S_C = 3'd2;
  localparam logic [2:0] S_D = 3'd3;
  localparam logic [2:0] S_E = 3'd4;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} ctrl_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
endpackage

// File: rtl/seq_recog_sched_core.sv
// recog_core: 5-state Moore symbol recognizer, E absorbing
module recog_core
  import seq_recog_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  input  logic       i1,
  input  logic       i2,
  output logic [2:0] state,
  output logic       in_a
);
  logic [1:0] s;
  logic [2:0] nxt;
  assign s = {i1, i2};
  always_comb begin
    nxt = S_A;
    case (state)
      S_A: nxt = s == 2'b00 ? S_A : s == 2'b01 ? S_C : s == 2'b10 ? S_B : S_E;
      S_B: nxt = s == 2'b00 ? S_D : S_E;
      S_C: nxt = s == 2'b00 ? S_A : s == 2'b10 ? S_B : S_E;
      S_D: nxt = s == 2'b00 ? S_A : S_E;
      S_E: nxt = S_E;
      default: nxt = S_A;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_A;
    else if (clear) state <= S_A;
    else if (step) state <= nxt;
  assign in_a = state == S_A;
endmodule

// File: rtl/seq_recog_sched.sv
// seq_recog_sched: round-robin scheduler sharing one recognizer between two symbol streams
module seq_recog_sched
  import seq_recog_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [3:0]    req_sym,
  input  logic [1:0]    req_last,
  output logic [1:0]    req_ready,
  output logic          resp_valid,
  output logic          resp_id,
  output logic          resp_accept,
  output logic          resp_trap,
  output logic [1:0]    resp_err,
  output logic [LW-1:0] resp_len,
  output logic          busy,
  output logic [2:0]    core_state
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  ctrl_t         st;
  logic          grant, ptr, hs, last, step, tmo_hit, rpt, in_a;
  logic [1:0]    ready, err, sym;
  logic [LW-1:0] len;
  logic [TW-1:0] tmo;
  logic [2:0]    cs;
  assign hs      = |(req_valid & ready);
  assign last    = hs & req_last[grant];
  assign sym     = grant ? req_sym[3:2] : req_sym[1:0];
  assign step    = hs && len < MAXL;
  assign tmo_hit = !hs && tmo == TLIM;
  recog_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clear (st == CLEAR),
    .step  (step),
    .i1    (sym[1]),
    .i2    (sym[0]),
    .state (cs),
    .in_a  (in_a)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      grant <= 1'b0;
      ptr   <= 1'b0;
      ready <= 2'b00;
      len   <= '0;
      err   <= ERR_NONE;
      tmo   <= '0;
    end else begin
      case (st)
        IDLE: if (|req_valid) begin
          grant <= req_valid[ptr] ? ptr : ~ptr;
          st    <= CLEAR;
        end
        CLEAR: begin
          len   <= '0;
          err   <= ERR_NONE;
          tmo   <= '0;
          ready <= grant ? 2'b10 : 2'b01;
          st    <= RUN;
        end
        RUN: begin
          if (hs) begin
            tmo <= '0;
            len <= len == MAXL ? len : len + 1'b1;
            if (len == MAXL) err <= ERR_OVF;
          end else tmo <= tmo + 1'b1;
          // an earlier overflow outranks the timeout code
          if (tmo_hit && err != ERR_OVF) err <= ERR_TMO;
          if (last || tmo_hit) begin
            ready <= 2'b00;
            st    <= REPORT;
          end
        end
        REPORT: begin
          ptr <= ~grant;
          st  <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
  // E is absorbing until CLEAR, so the core being in E at REPORT means a trap occurred
  assign rpt         = st == REPORT;
  assign req_ready   = ready;
  assign resp_valid  = rpt;
  assign resp_id     = rpt & grant;
  assign resp_accept = rpt & in_a & (err == ERR_NONE);
  assign resp_trap   = rpt & (cs == S_E);
  assign resp_err    = rpt ? err : ERR_NONE;
  assign resp_len    = rpt ? len : '0;
  assign busy        = st != IDLE;
  assign core_state  = cs;
endmodule

// File: tb/tb_seq_recog_sched.sv
// tb_seq_recog_sched: directed self-checking bench for the shared recognizer scheduler
module tb_seq_recog_sched;
  logic       clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_last = 0, req_ready, resp_err;
  logic [3:0] req_sym = 0;
  logic       resp_valid, resp_id, resp_accept, resp_trap, busy;
  logic [4:0] resp_len;
  logic [2:0] core_state;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct packed {logic id; logic acc; logic trap; logic [1:0] err; logic [4:0] len;} resp_t;
  resp_t rq[$];
  int rc[$];
  seq_recog_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sym(req_sym), .req_last(req_last),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_accept(resp_accept),
    .resp_trap(resp_trap), .resp_err(resp_err), .resp_len(resp_len), .busy(busy), .core_state(core_state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resp_valid) begin
    rq.push_back({resp_id, resp_accept, resp_trap, resp_err, resp_len});
    rc.push_back(cyc);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [1:0] s, input logic l, output int t);
    int n = 0;
    req_valid[k] = 1'b1;
    req_sym[2*k +: 2] = s;
    req_last[k] = l;
    do begin @(negedge clk); n++; end while (!req_ready[k] && n < 40);
    t = cyc;
    checks++;
    if (!req_ready[k]) begin errors++; $display("FAIL handshake req%0d: ready never rose in %0d cycles", k, n); end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_last[k] = 1'b0;
  endtask

  task automatic get_resp(output resp_t r, output int c, output bit ok);
    for (int i = 0; i < 30 && rq.size() == 0; i++) begin @(negedge clk); #1; end
    ok = rq.size() != 0;
    r = '0;
    c = -1;
    if (ok) begin r = rq.pop_front(); c = rc.pop_front(); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_accept, resp_trap, resp_err, resp_len, busy, core_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b err=%b len=%0d busy=%b core=%0d, want all 0",
               req_ready, resp_valid, resp_err, resp_len, busy, core_state);
    end
    rst = 0;
  endtask

  task automatic test_accept();
    logic [1:0] syms [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
    logic [2:0] sts  [4] = '{3'd2, 3'd1, 3'd3, 3'd0};
    int t, c, c0;
    resp_t r, e;
    bit ok;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push(0, syms[i], i == 3, t);
      if (i == 0) begin
        checks++;
        if (t !== c0 + 2) begin errors++; $display("FAIL grant_latency got %0d want %0d", t - c0, 2); end
      end
      checks++;
      if (core_state !== sts[i]) begin errors++; $display("FAIL accept_core step%0d got %0d want %0d", i, core_state, sts[i]); end
    end
    get_resp(r, c, ok);
    e = {1'b0, 1'b1, 1'b0, 2'b00, 5'd4};
    checks++;
    if (!ok || r !== e) begin errors++; $display("FAIL accept_resp got %h want %h (ok=%0d)", r, e, ok); end
    checks++;
    if (c !== t + 1) begin errors++; $display("FAIL accept_latency got %0d want %0d", c, t + 1); end
  endtask

  task automatic test_trap();
    logic [1:0] syms [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
    logic [2:0] sts  [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    int t, c;
    resp_t r, e;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      push(1, syms[i], i == 3, t);
      checks++;
      if (core_state !== sts[i]) begin errors++; $display("FAIL trap_core step%0d got %0d want %0d", i, core_state, sts[i]); end
    end
    get_resp(r, c, ok);
    e = {1'b1, 1'b0, 1'b1, 2'b00, 5'd4};
    checks++;
    if (!ok || r !== e) begin errors++; $display("FAIL trap_resp got %h want %h (ok=%0d)", r, e, ok); end
  endtask

  task automatic test_single();
    int t, c;
    resp_t r, e;
    bit ok;
    @(posedge clk); #1;
    push(0, 2'b00, 1'b1, t);
    get_resp(r, c, ok);
    e = {1'b0, 1'b1, 1'b0, 2'b00, 5'd1};
    checks++;
    if (!ok || r !== e) begin errors++; $display("FAIL single00_resp got %h want %h (ok=%0d)", r, e, ok); end
    checks++;
    if (c !== t + 1) begin errors++; $display("FAIL single00_latency got %0d want %0d", c, t + 1); end
    @(posedge clk); #1;
    push(0, 2'b11, 1'b1, t);
    get_resp(r, c, ok);
    e = {1'b0, 1'b0, 1'b1, 2'b00, 5'd1};
    checks++;
    if (!ok || r !== e) begin errors++; $display("FAIL single11_resp got %h want %h (ok=%0d)", r, e, ok); end
    checks++;
    if (c !== t + 1) begin errors++; $display("FAIL single11_latency got %0d want %0d", c, t + 1); end
  endtask

  task automatic test_overflow();
    int t, c;
    resp_t r, e;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) push(0, 2'b00, i == 19, t);
    get_resp(r, c, ok);
    e = {1'b0, 1'b0, 1'b0, 2'b01, 5'd16};
    checks++;
    if (!ok || r !== e) begin errors++; $display("FAIL overflow_resp got %h want %h (ok=%0d)", r, e, ok); end
    checks++;
    if (c !== t + 1) begin errors++; $display("FAIL overflow_latency got %0d want %0d", c, t + 1); end
  endtask

  task automatic test_timeout();
    int t, c;
    resp_t r, e;
    bit ok;
    @(posedge clk); #1;
    push(0, 2'b01, 1'b0, t);
    push(0, 2'b10, 1'b0, t);
    get_resp(r, c, ok);
    e = {1'b0, 1'b0, 1'b0, 2'b10, 5'd2};
    checks++;
    if (!ok || r !== e) begin errors++; $display("FAIL timeout_resp got %h want %h (ok=%0d)", r, e, ok); end
    checks++;
    if (c !== t + 9) begin errors++; $display("FAIL timeout_latency got %0d want %0d", c, t + 9); end
  endtask

  task automatic test_reset_mid();
    int t, n;
    @(posedge clk); #1;
    push(0, 2'b01, 1'b0, t);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", req_ready); end
    checks++;
    if (core_state !== 3'd0) begin errors++; $display("FAIL rst_core got %0d want 0", core_state); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    n = rq.size();
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (rq.size() !== n) begin errors++; $display("FAIL rst_no_resp got %0d resps want %0d", rq.size(), n); end
  endtask

  task automatic test_back_to_back();
    int ta, tb1, tb2, c;
    int rcs [3];
    resp_t r;
    resp_t e [3];
    bit ok;
    e[0] = {1'b0, 1'b1, 1'b0, 2'b00, 5'd2};
    e[1] = {1'b1, 1'b0, 1'b0, 2'b00, 5'd1};
    e[2] = {1'b0, 1'b1, 1'b0, 2'b00, 5'd1};
    @(posedge clk); #1;
    fork
      begin
        push(0, 2'b01, 1'b0, ta);
        push(0, 2'b00, 1'b1, ta);
        push(0, 2'b00, 1'b1, ta);
      end
      push(1, 2'b10, 1'b1, tb1);
    join
    for (int i = 0; i < 3; i++) begin
      get_resp(r, c, ok);
      rcs[i] = c;
      checks++;
      if (!ok || r !== e[i]) begin errors++; $display("FAIL rr_resp%0d got %h want %h (ok=%0d)", i, r, e[i], ok); end
    end
    checks++;
    if (tb1 <= rcs[0]) begin errors++; $display("FAIL rr_ready1_early got cycle %0d want after %0d", tb1, rcs[0]); end
    tb2 = rcs[1];
    checks++;
    if (ta <= tb2) begin errors++; $display("FAIL rr_req0_second got cycle %0d want after %0d", ta, tb2); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_trap();
    test_single();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
